// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size/state types, be code constants and lane helpers
package mem_pkg;
  typedef enum logic [1:0] {WORD, HALF, BYTE} size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;
  localparam logic [3:0] BE_WORD   = 4'b0000;
  localparam logic [3:0] BE_HALF_U = 4'b0011;
  localparam logic [3:0] BE_HALF_S = 4'b0100;
  function automatic logic be_legal(logic [3:0] be);
    return be[3] || be == BE_WORD || be == BE_HALF_U || be == BE_HALF_S;
  endfunction
  function automatic size_e be_size(logic [3:0] be);
    return be[3] ? BYTE : be == BE_WORD ? WORD : HALF;
  endfunction
  function automatic logic [3:0] lane_strb(size_e sz, logic [1:0] bl, logic hi);
    return sz == WORD ? 4'b1111 : sz == HALF ? (hi ? 4'b1100 : 4'b0011) : 4'b0001 << bl;
  endfunction
  function automatic logic [31:0] lane_wdata(size_e sz, logic [31:0] d);
    return sz == WORD ? d : sz == HALF ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-addressed data memory bus with req/gnt/rvalid handshake
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: lane select plus zero/sign extension of a loaded word
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  be,
  input  logic        hi,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sgn;
  size_e       sz;
  // byte lane comes from the be code, halfword lane from address bit 1
  always_comb begin
    sz = be_size(be);
    b = word[{be[1:0], 3'b000} +: 8];
    h = hi ? word[31:16] : word[15:0];
    sgn = sz == BYTE ? be[2] : be == BE_HALF_S;
    result = sz == WORD ? word : sz == HALF ? {{16{sgn & h[15]}}, h} : {{24{sgn & b[7]}}, b};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bus executor with lane strobes and load extension; MEM_ACCESS_ALIGN_CHECK_EN adds misalignment faults
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              fault,
  mem_access_unit_if.master bus
);
  state_e      state, nxt;
  size_e       sz;
  logic        r_load, r_hi, r_flt, n_flt, misal, bad, tmo, cap;
  logic [3:0]  r_be, r_strb;
  logic [29:0] r_word;
  logic [31:0] r_wdata, cnt, ext;

  assign sz = be_size(be);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misal = (sz == WORD && addr[1:0] != 2'b00) || (sz == HALF && addr[0]);
`else
  logic unused_addr;
  assign unused_addr = addr[0];
  assign misal = 1'b0;
`endif
  assign bad = !be_legal(be) || misal;
  assign tmo = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
  assign cap = r_load && bus.rvalid && ((state == REQ && bus.gnt) || state == WAIT_R);

  // next state; n_flt is only consumed on the edge that enters RESP
  always_comb begin
    nxt = state;
    n_flt = 1'b0;
    case (state)
      IDLE: begin
        nxt = start ? (bad ? RESP : REQ) : IDLE;
        n_flt = bad;
      end
      REQ: begin
        nxt = bus.gnt ? ((r_load && !bus.rvalid) ? WAIT_R : RESP) : (tmo ? RESP : REQ);
        n_flt = !bus.gnt;
      end
      WAIT_R: begin
        nxt = (bus.rvalid || tmo) ? RESP : WAIT_R;
        n_flt = !bus.rvalid;
      end
      default: nxt = IDLE;
    endcase
  end

  // state, fault flag, wait counter and load result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r_flt <= 1'b0;
      cnt <= '0;
      rdata_ext <= '0;
    end else begin
      state <= nxt;
      r_flt <= n_flt;
      cnt <= (nxt == state && state inside {REQ, WAIT_R}) ? cnt + 32'd1 : '0;
      if (cap) rdata_ext <= ext;
    end
  end

  // request capture; strobes and store data are formed once so they stay stable in REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load <= 1'b0;
      r_be <= '0;
      r_hi <= 1'b0;
      r_word <= '0;
      r_strb <= '0;
      r_wdata <= '0;
    end else if (state == IDLE && start) begin
      r_load <= is_load;
      r_be <= be;
      r_hi <= addr[1];
      r_word <= addr[31:2];
      r_strb <= lane_strb(sz, be[1:0], addr[1]);
      r_wdata <= lane_wdata(sz, wdata);
    end
  end

  load_extend u_ext (.word(bus.rdata), .be(r_be), .hi(r_hi), .result(ext));

  assign busy = state != IDLE;
  assign done = state == RESP && !r_flt;
  assign fault = state == RESP && r_flt;
  assign bus.req = state == REQ;
  assign bus.we = bus.req && !r_load;
  assign bus.addr = {r_word, 2'b00};
  assign bus.wstrb = r_strb;
  assign bus.wdata = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;
  logic clk = 0, reset = 1, start = 0, start4 = 0, is_load = 0;
  logic [3:0] be = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic busy, done, fault, busy4, done4, fault4;
  logic [31:0] rdata_ext, rdata4;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_rd = 0;
  int o_done_cyc, o_fault_cyc, o_reqs, o_dones, o_faults;
  logic o_stable, o_busy_ok, o_busy_after, o_we;
  logic [31:0] o_res, o_addr, o_wdata;
  logic [3:0] o_strb;

  always #5 clk = ~clk;

  mem_access_unit_if bus();
  mem_access_unit_if bus4();

  mem_access_unit dut (.clk(clk), .reset(reset), .start(start), .is_load(is_load), .be(be), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata_ext(rdata_ext), .fault(fault), .bus(bus));
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .is_load(is_load),
    .be(be), .addr(addr), .wdata(wdata), .busy(busy4), .done(done4), .rdata_ext(rdata4), .fault(fault4), .bus(bus4));

  function automatic logic m_legal(logic [3:0] b, logic [31:0] a);
    logic ok;
    ok = b == 0 || b == 3 || b == 4 || b >= 8;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (b == 0 && a % 4 != 0) ok = 0;
    if ((b == 3 || b == 4) && a % 2 != 0) ok = 0;
`else
    if (a === 32'hx) ok = 0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] m_ext(logic [3:0] b, logic [31:0] a, logic [31:0] w);
    int unsigned v;
    if (b == 0) return w;
    if (b < 8) begin
      v = (w >> (a[1] ? 16 : 0)) % 65536;
      if (b == 4 && v >= 32768) v += 32'hFFFF0000;
    end else begin
      v = (w >> (8 * (b % 4))) % 256;
      if (b >= 12 && v >= 128) v += 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(logic [3:0] b, logic [31:0] a);
    return b == 0 ? 4'd15 : b < 8 ? (a[1] ? 4'd12 : 4'd3) : 4'(1 << (b % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [3:0] b, logic [31:0] w);
    return b == 0 ? w : b < 8 ? (w % 65536) * 32'h10001 : (w % 256) * 32'h01010101;
  endfunction

  task automatic run_txn(input logic ld, input logic [3:0] b, input logic [31:0] a, wd, rd,
                         input int gd, rdl, input logic hold);
    int c, gc, end_c;
    c = 0; gc = -1; end_c = -1;
    o_done_cyc = -1; o_fault_cyc = -1; o_reqs = 0; o_dones = 0; o_faults = 0;
    o_stable = 1; o_busy_ok = 1; o_busy_after = 1'bx; o_res = 'x;
    o_addr = 'x; o_strb = 'x; o_wdata = 'x; o_we = 1'bx;
    is_load = ld; be = b; addr = a; wdata = wd; bus.rdata = rd; start = 1;
    while (c < 60 && (end_c < 0 || c < end_c)) begin
      @(posedge clk); #1; c++;
      if (!hold) start = 0;
      if (bus.req) begin
        if (o_reqs == 0) begin o_addr = bus.addr; o_strb = bus.wstrb; o_wdata = bus.wdata; o_we = bus.we; end
        else if ({bus.addr, bus.wstrb, bus.wdata, bus.we} !== {o_addr, o_strb, o_wdata, o_we}) o_stable = 0;
        o_reqs++;
      end
      if (done) begin o_dones++; if (o_done_cyc < 0) begin o_done_cyc = c; o_res = rdata_ext; end end
      if (fault) begin o_faults++; if (o_fault_cyc < 0) o_fault_cyc = c; end
      if (end_c < 0 && (done || fault)) end_c = c + 1;
      if (c == end_c) o_busy_after = busy; else if (!busy) o_busy_ok = 0;
      bus.gnt = bus.req && (o_reqs > gd);
      if (bus.gnt && gc < 0) gc = c;
      bus.rvalid = ld && gc >= 0 && c == gc + rdl;
    end
    start = 0; bus.gnt = 0; bus.rvalid = 0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if ({busy, done, fault, bus.req, bus.we} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fault, bus.req, bus.we}); end
    n_cmp++; if ({bus.addr, bus.wstrb, bus.wdata, rdata_ext} !== 100'b0) begin n_bad++; $display("FAIL reset_data: got %h %h %h %h want 0", bus.addr, bus.wstrb, bus.wdata, rdata_ext); end
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_store_byte;
    run_txn(0, 4'b1010, 32'h1002, 32'hAB, 0, 0, 0, 0);
    n_cmp++; if (o_strb !== 4'b0100) begin n_bad++; $display("FAIL sb_strb: got %b want 0100", o_strb); end
    n_cmp++; if (o_wdata !== 32'hABABABAB) begin n_bad++; $display("FAIL sb_wdata: got %h want ababab ab", o_wdata); end
    n_cmp++; if (o_addr !== 32'h1000) begin n_bad++; $display("FAIL sb_addr: got %h want 00001000", o_addr); end
    n_cmp++; if (o_we !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b want 1", o_we); end
    n_cmp++; if (o_done_cyc !== 2 || o_dones !== 1) begin n_bad++; $display("FAIL sb_done: got cyc %0d cnt %0d want 2/1", o_done_cyc, o_dones); end
    n_cmp++; if (rdata_ext !== exp_rd) begin n_bad++; $display("FAIL sb_rdata_hold: got %h want %h", rdata_ext, exp_rd); end
  endtask

  task automatic test_load_byte;
    run_txn(1, 4'b1101, 32'h0, 0, 32'h00008000, 0, 1, 0);
    n_cmp++; if (o_res !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_signed: got %h want ffffff80", o_res); end
    n_cmp++; if (o_done_cyc !== 3) begin n_bad++; $display("FAIL lb_latency: got %0d want 3", o_done_cyc); end
    run_txn(1, 4'b1001, 32'h0, 0, 32'h00008000, 0, 1, 0);
    n_cmp++; if (o_res !== 32'h00000080) begin n_bad++; $display("FAIL lb_unsigned: got %h want 00000080", o_res); end
    exp_rd = 32'h00000080;
  endtask

  task automatic test_load_half;
    run_txn(1, 4'b0100, 32'h2002, 0, 32'h92345678, 0, 1, 0);
    n_cmp++; if (o_res !== 32'hFFFF9234) begin n_bad++; $display("FAIL lh_signed: got %h want ffff9234", o_res); end
    n_cmp++; if (o_strb !== 4'b1100 || o_addr !== 32'h2000) begin n_bad++; $display("FAIL lh_bus: got %b %h want 1100 00002000", o_strb, o_addr); end
    run_txn(1, 4'b0011, 32'h2002, 0, 32'h92345678, 0, 1, 0);
    n_cmp++; if (o_res !== 32'h00009234) begin n_bad++; $display("FAIL lh_unsigned: got %h want 00009234", o_res); end
    exp_rd = 32'h00009234;
  endtask

  task automatic test_stall;
    logic [31:0] rd;
    rd = $urandom;
    run_txn(1, 4'b0000, 32'h4440, 0, rd, 5, 3, 0);
    n_cmp++; if (o_reqs !== 6 || o_stable !== 1'b1) begin n_bad++; $display("FAIL stall_req: got %0d cycles stable %b want 6/1", o_reqs, o_stable); end
    n_cmp++; if (o_dones !== 1 || o_done_cyc !== 10) begin n_bad++; $display("FAIL stall_done: got cnt %0d cyc %0d want 1/10", o_dones, o_done_cyc); end
    n_cmp++; if (o_busy_ok !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", o_busy_ok); end
    n_cmp++; if (o_res !== rd) begin n_bad++; $display("FAIL stall_data: got %h want %h", o_res, rd); end
    exp_rd = rd;
  endtask

  task automatic test_illegal;
    run_txn(1, 4'b0101, 32'h10, 0, 32'h12345678, 0, 0, 0);
    n_cmp++; if (o_fault_cyc !== 1 || o_faults !== 1 || o_dones !== 0) begin n_bad++; $display("FAIL illegal_fault: got cyc %0d f %0d d %0d want 1/1/0", o_fault_cyc, o_faults, o_dones); end
    n_cmp++; if (o_reqs !== 0) begin n_bad++; $display("FAIL illegal_req: got %0d want 0", o_reqs); end
    n_cmp++; if (rdata_ext !== exp_rd) begin n_bad++; $display("FAIL illegal_rdata_hold: got %h want %h", rdata_ext, exp_rd); end
  endtask

  task automatic test_timeout;
    int reqs, fc, faults, dones;
    logic req_at_fault;
    reqs = 0; fc = -1; faults = 0; dones = 0; req_at_fault = 1'bx;
    is_load = 0; be = 4'b0000; addr = 32'h40; wdata = 32'h5; start4 = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1 start4 = 0;
      if (bus4.req) reqs++;
      if (done4) dones++;
      if (fault4) begin faults++; if (fc < 0) begin fc = c; req_at_fault = bus4.req; end end
    end
    n_cmp++; if (reqs !== 4) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 4", reqs); end
    n_cmp++; if (fc !== 5 || faults !== 1 || dones !== 0) begin n_bad++; $display("FAIL timeout_fault: got cyc %0d f %0d d %0d want 5/1/0", fc, faults, dones); end
    n_cmp++; if (req_at_fault !== 1'b0) begin n_bad++; $display("FAIL timeout_req_drop: got %b want 0", req_at_fault); end
  endtask

  task automatic test_reset_mid;
    int evts;
    is_load = 1; be = 4'b0000; addr = 32'h10; start = 1;
    @(posedge clk); #1 start = 0;
    bus.gnt = bus.req;
    @(posedge clk); #1 bus.gnt = 0;
    n_cmp++; if ({busy, bus.req} !== 2'b10) begin n_bad++; $display("FAIL mid_wait_r: got busy/req %b want 10", {busy, bus.req}); end
    #2 reset = 1;
    #1;
    n_cmp++; if ({busy, done, fault, bus.req, bus.we} !== 5'b0) begin n_bad++; $display("FAIL mid_reset_ctrl: got %b want 00000", {busy, done, fault, bus.req, bus.we}); end
    n_cmp++; if ({bus.addr, bus.wstrb, bus.wdata, rdata_ext} !== 100'b0) begin n_bad++; $display("FAIL mid_reset_data: got %h %h %h %h want 0", bus.addr, bus.wstrb, bus.wdata, rdata_ext); end
    exp_rd = 0;
    @(posedge clk); #1 reset = 0;
    bus.rvalid = 1; bus.rdata = 32'hDEADBEEF;
    evts = 0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (done || fault || busy) evts++; end
    bus.rvalid = 0;
    n_cmp++; if (evts !== 0 || rdata_ext !== 32'h0) begin n_bad++; $display("FAIL mid_reset_quiet: got events %0d rdata %h want 0/0", evts, rdata_ext); end
  endtask

  task automatic test_align;
    run_txn(1, 4'b0000, 32'h3, 0, 32'hCAFEF00D, 0, 1, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    n_cmp++; if (o_fault_cyc !== 1 || o_dones !== 0) begin n_bad++; $display("FAIL align_fault: got cyc %0d d %0d want 1/0", o_fault_cyc, o_dones); end
    n_cmp++; if (o_reqs !== 0) begin n_bad++; $display("FAIL align_req: got %0d want 0", o_reqs); end
`else
    n_cmp++; if (o_done_cyc !== 3 || o_res !== 32'hCAFEF00D) begin n_bad++; $display("FAIL align_ignored: got cyc %0d data %h want 3 cafef00d", o_done_cyc, o_res); end
    n_cmp++; if (o_addr !== 32'h0) begin n_bad++; $display("FAIL align_addr: got %h want 0", o_addr); end
    exp_rd = 32'hCAFEF00D;
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    run_txn(0, 4'b0000, 32'h80, 32'h11223344, 0, 2, 0, 1);
    n_cmp++; if (o_dones !== 1 || o_done_cyc !== 4) begin n_bad++; $display("FAIL b2b_ignore_start: got cnt %0d cyc %0d want 1/4", o_dones, o_done_cyc); end
    n_cmp++; if (o_busy_after !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after_resp: got %b want 0", o_busy_after); end
    rd = $urandom;
    run_txn(1, 4'b1110, 32'h84, 0, rd, 0, 0, 0);
    n_cmp++; if (o_done_cyc !== 2 || o_res !== m_ext(4'b1110, 32'h84, rd)) begin n_bad++; $display("FAIL b2b_restart: got cyc %0d data %h want 2 %h", o_done_cyc, o_res, m_ext(4'b1110, 32'h84, rd)); end
    exp_rd = m_ext(4'b1110, 32'h84, rd);
  endtask

  task automatic test_random;
    logic ld;
    logic [3:0] b;
    logic [31:0] a, wd, rd;
    int gd, rdl, exp_cyc;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1)); b = 4'($urandom_range(0, 15)); a = $urandom; wd = $urandom; rd = $urandom;
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      run_txn(ld, b, a, wd, rd, gd, rdl, 0);
      if (!m_legal(b, a)) begin
        n_cmp++; if (o_fault_cyc !== 1 || o_dones !== 0 || o_reqs !== 0) begin n_bad++; $display("FAIL rnd%0d_illegal: be %b got cyc %0d d %0d req %0d want 1/0/0", i, b, o_fault_cyc, o_dones, o_reqs); end
      end else begin
        exp_cyc = ld ? gd + rdl + 2 : gd + 2;
        n_cmp++; if (o_done_cyc !== exp_cyc || o_dones !== 1 || o_faults !== 0) begin n_bad++; $display("FAIL rnd%0d_done: got cyc %0d d %0d f %0d want %0d/1/0", i, o_done_cyc, o_dones, o_faults, exp_cyc); end
        n_cmp++; if ({o_addr, o_strb, o_we} !== {a & 32'hFFFFFFFC, m_strb(b, a), !ld}) begin n_bad++; $display("FAIL rnd%0d_bus: got %h %b %b want %h %b %b", i, o_addr, o_strb, o_we, a & 32'hFFFFFFFC, m_strb(b, a), !ld); end
        if (ld) begin
          n_cmp++; if (o_res !== m_ext(b, a, rd)) begin n_bad++; $display("FAIL rnd%0d_load: be %b got %h want %h", i, b, o_res, m_ext(b, a, rd)); end
          exp_rd = m_ext(b, a, rd);
        end else begin
          n_cmp++; if (o_wdata !== m_wdata(b, wd)) begin n_bad++; $display("FAIL rnd%0d_wdata: be %b got %h want %h", i, b, o_wdata, m_wdata(b, wd)); end
        end
      end
      n_cmp++; if (rdata_ext !== exp_rd) begin n_bad++; $display("FAIL rnd%0d_rdata_ext: got %h want %h", i, rdata_ext, exp_rd); end
    end
  endtask

  initial begin
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    bus4.gnt = 0; bus4.rvalid = 0; bus4.rdata = 0;
    test_reset;
    test_store_byte;
    test_load_byte;
    test_load_half;
    test_stall;
    test_illegal;
    test_timeout;
    test_align;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side executor for the byte-enable code produced by the core's load/store control path.
- Accepts one load/store request per transaction with its 4-bit be code, byte address and store data.
- Runs a req/gnt/rvalid handshake to word-addressed data memory, drives per-lane write strobes with replicated store data, and returns the aligned, zero- or sign-extended load result for register writeback.
- Sits between the datapath's memory stage and the data RAM/bus.

Parameters:
- DATA_W, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum wait cycles for gnt or rvalid before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_load  in  1  1 = load, 0 = store
- be  in  4  access code (see Behaviour)
- addr  in  32  byte address
- wdata  in  32  store data, low-aligned
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rdata_ext  out  32  extended load result; valid when done is high
- fault  out  1  one-cycle pulse, replaces done on error
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address = {addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane strobes
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; the timeout counter clears. A reset mid-transaction aborts it with no done or fault pulse.
- be decode:
  - 0000: word.
  - 0011: unsigned halfword at lane addr[1].
  - 0100: signed halfword at lane addr[1].
  - 10bb: unsigned byte at lane bb.
  - 11bb: signed byte at lane bb.
  - Any other code is illegal.
- Strobes: word 1111; halfword 0011 or 1100; byte one-hot lane.
- mem_wdata: word as-is; halfword {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- FSM states: IDLE, REQ, WAIT_R, RESP.
  - IDLE: if start, register all request inputs. An illegal code goes to RESP with fault. Otherwise go to REQ.
  - REQ: mem_req=1, with address, strobes, mem_we and mem_wdata held stable. On mem_gnt, a store goes to RESP with done and a load goes to WAIT_R. mem_gnt and mem_rvalid in the same cycle are legal; a load then goes straight to RESP.
  - WAIT_R: mem_req=0. On mem_rvalid, capture mem_rdata, extract and extend it, then go to RESP with done.
  - RESP: exactly one cycle with done or fault = 1, then IDLE. start is ignored in RESP; earliest back-to-back restart is the cycle after RESP.
- Latency: a store with gnt in the first REQ cycle gives done 2 cycles after start. A load with gnt and rvalid 1 cycle apart gives done 3 cycles after start.
- Extraction: select the lane, then zero-extend or sign-extend from bit 7 or bit 15. Word loads pass through unchanged.
- rdata_ext holds its last value until the next load completes. Stores and faults leave it unchanged.
- Timeout: the counter increments each cycle in REQ or WAIT_R and resets on each state change. Reaching TIMEOUT_CYCLES forces RESP with fault and drops mem_req.
- start while busy is ignored; no queuing.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]≠00, faults directly from IDLE. No bus cycle is issued and mem_req stays 0.
- Undefined: low address bits are ignored for halfword and word; the lane is addr[1] for halfword and 0 for word.

Decomposition:
- Shared package mem_pkg:
  - access-size enum (WORD, HALF, BYTE);
  - be code constants BE_WORD=4'b0000, BE_HALF_U=4'b0011, BE_HALF_S=4'b0100;
  - FSM state typedef.
- One sub-module, load_extend: combinational lane select plus zero/sign extension, shared with the datapath's forwarding logic.

Test Plan:
- Store byte: be=4'b1010, addr=0x1002, wdata=0xAB. Required: mem_wstrb=0100, mem_wdata=0xABABABAB, mem_addr=0x1000, done 2 cycles after start with gnt immediate.
- Signed byte load: be=4'b1101, mem_rdata=0x0000_8000. Required: rdata_ext=0xFFFFFF80. Repeat with be=4'b1001; required rdata_ext=0x00000080.
- Signed halfword load: be=4'b0100, addr=0x2002, mem_rdata=0x9234_5678. Required: rdata_ext=0xFFFF9234. Unsigned be=4'b0011, same address and data; required rdata_ext=0x00009234.
- Stall: gnt delayed 5 cycles, rvalid delayed 3 more. Required: mem_req held with stable address/strobes; a single done pulse; busy high throughout.
- Illegal be=4'b0101 → fault pulse 1 cycle after start, mem_req never asserted. Timeout with TIMEOUT_CYCLES=4 and gnt never asserted → fault after 4 REQ cycles, mem_req drops.
- Reset asserted in WAIT_R → all outputs 0 immediately, no done. With MEM_ACCESS_ALIGN_CHECK_EN, word load at addr=0x3 → fault, no mem_req.
